lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_pkg.sv | 54 +++++
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_align.sv | 27 ++
 rtl/lsu_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared types for the load/store unit controller.
// Holds func3 width codes, FSM state encoding, byte-enable patterns, lane helpers.
package lsu_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H    = 4'b0011;
    localparam logic [3:0] BE_W    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Unknown func3 codes behave as a full word.
    function automatic size_t f3_size(input logic [2:0] f3);
        unique case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    // Byte lane used by the access; low bits are dropped to force natural alignment.
    function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
        unique case (f3_size(f3))
            SZ_B:    return a;
            SZ_H:    return {a[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        unique case (f3_size(f3))
            SZ_B:    return 1'b0;
            SZ_H:    return a[0];
            default: return |a;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: CPU-side request/response and memory-side bus of the LSU.
// master = LSU controller, slave = surrounding CPU + memory environment.
interface lsu_ctrl_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_rdata;
    logic        mem_busywait;
    logic        misalign_err;

    modport master (
        input  cpu_read, cpu_write, func3, addr, wdata,
        input  mem_rdata, mem_busywait,
        output rdata, busywait, misalign_err,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
    );

    modport slave (
        output cpu_read, cpu_write, func3, addr, wdata,
        output mem_rdata, mem_busywait,
        input  rdata, busywait, misalign_err,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
    );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: shifts the addressed lane of a memory word down and sign/zero extends it.
// Ports: word (memory word), off (byte offset), func3 (width code) -> data (extended).
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] data
);

    logic [15:0] lane;

    assign lane = 16'(word >> {off, 3'b000});

    always_comb begin
        data = word;
        unique case (func3)
            F3_B:    data = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   data = {24'd0, lane[7:0]};
            F3_H:    data = {{16{lane[15]}}, lane};
            F3_HU:   data = {16'd0, lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller, IDLE->ACCESS->RESP FSM between CPU and word memory.
// Ports: clk, reset (sync, active-high), bus (lsu_ctrl_if.master). Option: MISALIGN_CHECK_EN.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    lsu_ctrl_if.master  bus
);

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic [2:0]  func3_q;
    logic [31:0] wdata_q;
    logic        store_q;
    logic        mis_q;
    logic [31:0] rdata_q;

    logic        req;
    logic        mis_now;
    logic [1:0]  off;
    logic [31:0] aligned;
    logic        busy;
    logic        rd_en;
    logic        wr_en;
    logic [3:0]  be;
    logic [31:0] wd;
    size_t       sz;

    assign req = bus.cpu_read | bus.cpu_write;
    assign off = lane_off(func3_q, addr_q[1:0]);
    assign sz  = f3_size(func3_q);

`ifdef MISALIGN_CHECK_EN
    assign mis_now          = misaligned(bus.func3, bus.addr[1:0]);
    assign bus.misalign_err = (state == ST_RESP) && mis_q;
`else
    assign mis_now          = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif

    lsu_align u_align (
        .word  (bus.mem_rdata),
        .off   (off),
        .func3 (func3_q),
        .data  (aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            store_q <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req) begin
                addr_q  <= bus.addr;
                func3_q <= bus.func3;
                wdata_q <= bus.wdata;
                // a simultaneous read is dropped in favour of the store
                store_q <= bus.cpu_write;
                mis_q   <= mis_now;
            end
            if (state == ST_ACCESS && state_nx == ST_RESP && !store_q) begin
                rdata_q <= mis_q ? '0 : aligned;
            end
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    busy     = 1'b1;
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy  = 1'b1;
                rd_en = !store_q && !mis_q;
                wr_en = store_q && !mis_q;
                // misaligned accesses never touch memory
                if (mis_q || !bus.mem_busywait) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        be = BE_W;
        wd = wdata_q;
        unique case (1'b1)
            sz == SZ_B: begin
                be = BE_B << off;
                wd = {4{wdata_q[7:0]}};
            end
            sz == SZ_H: begin
                be = BE_H << off;
                wd = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign bus.busywait   = busy;
    assign bus.mem_read   = rd_en;
    assign bus.mem_write  = wr_en;
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = wd;
    assign bus.mem_byteen = wr_en ? be : BE_NONE;
    assign bus.rdata      = rdata_q;

endmodule
